dma_descriptor_arbiter: RTL

Round-robin scheduler that shares the single DMA descriptor processor between up to `NUM_REQ` requesters. It accepts one descriptor at a time with a valid/ready handshake and presents it to the processor's `descp_avail`/`read_from`/`write_to`/`length_data` inputs. It holds those inputs stable for the whole transfer, detects completion when the processor returns to idle, and reports per-requester completion. It sits between the requester channels (CPU/video descriptor sources) and the descriptor processor.

---
 rtl/dma_descriptor_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dma_descriptor_arbiter.sv
// Round-robin front end for the shared DMA descriptor processor.
// Accepts one descriptor at a time from up to NUM_REQ requesters. It holds the
// descriptor on the processor inputs for the whole transfer. When the processor
// returns to idle, it pulses req_done for the owning channel.
module dma_descriptor_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*64-1:0]        req_src,
  input  logic [NUM_REQ*18-1:0]        req_dst,
  input  logic [NUM_REQ*16-1:0]        req_len,
  input  logic [NUM_REQ-1:0]           req_enable,
  output logic [NUM_REQ-1:0]           req_done,
  output logic                         descp_avail,
  output logic [63:0]                  read_from,
  output logic [17:0]                  write_to,
  output logic [63:0]                  length_data,
  input  logic                         proc_idle,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   cur_id
);

  localparam int          IDW = $clog2(NUM_REQ);
  localparam int unsigned NR  = NUM_REQ;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [63:0]    src_q, src_d;
  logic [17:0]    dst_q, dst_d;
  logic [15:0]    len_q, len_d;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_vld;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     cand;
  logic [63:0]        sel_src;
  logic [17:0]        sel_dst;
  logic [15:0]        sel_len;

  // Round-robin pick: scan from last_grant+1, first eligible channel wins.
  // Only idle-state requests are eligible, so req_ready is zero elsewhere.
  always_comb begin
    eligible  = (state_q == S_IDLE && proc_idle) ? (req_valid & req_enable) : '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % NR);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Select the winner's descriptor fields from the packed request buses.
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_src = req_src[64*i +: 64];
        sel_dst = req_dst[18*i +: 18];
        sel_len = req_len[16*i +: 16];
      end
    end
  end

  // Next-state and datapath capture; the descriptor is latched only on the handshake.
  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          src_d        = sel_src;
          dst_d        = sel_dst;
          len_d        = sel_len;
          cur_id_d     = grant_id;
          last_grant_d = grant_id;
          // Zero-length descriptors complete without touching the processor.
          state_d      = (sel_len == 16'd0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!proc_idle) state_d = S_RUN;
      end
      S_RUN: begin
        if (proc_idle) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only (glitch-free), plus the combinational grant.
  always_comb begin
    req_ready   = '0;
    req_done    = '0;
    descp_avail = (state_q == S_LAUNCH);
    busy        = (state_q != S_IDLE);
    if (grant_vld) req_ready[grant_id] = 1'b1;
    if (state_q == S_DONE) req_done[cur_id_q] = 1'b1;
    read_from   = src_q;
    write_to    = dst_q;
    length_data = {48'd0, len_q};
    cur_id      = cur_id_q;
  end

  // State and held-descriptor registers; reset gives channel 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_id_q     <= '0;
      last_grant_q <= IDW'(NR - 1);
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
    end
  end

endmodule
